// File: rtl/seq_mult_pkg.sv
// Shared FSM encoding and sizing helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-cycle counter width: one bit of headroom above the index range.
    function automatic int cnt_bits(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/seq_mult_if.sv
// Operand/result bus of the multiplier; master issues requests, slave computes.
interface seq_mult_if
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic [WIDTH-1:0]   iA;
    logic [WIDTH-1:0]   iB;
    logic               iSigned;
    logic               iStart;
    logic               oBusy;
    logic               oDone;
    logic [2*WIDTH-1:0] oResult;

    modport master (
        output iA, iB, iSigned, iStart,
        input  oBusy, oDone, oResult
    );

    modport slave (
        input  iA, iB, iSigned, iStart,
        output oBusy, oDone, oResult
    );

endinterface

// File: rtl/seq_mult_dp.sv
// Magnitude shift-add datapath: captures operands on load, consumes one
// multiplier bit per step, and applies the sign fix-up on the way out.
module seq_mult_dp
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      load_i,
    input  logic      step_i,
    seq_mult_if.slave bus
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             neg_q, neg_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // The most negative operand negates to itself, which is its correct
    // unsigned magnitude, so no extra bit is needed.
    always_comb begin
        a_neg = bus.iSigned & bus.iA[WIDTH-1];
        b_neg = bus.iSigned & bus.iB[WIDTH-1];
        a_mag = a_neg ? -bus.iA : bus.iA;
        b_mag = b_neg ? -bus.iB : bus.iB;
    end

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            neg_d    = a_neg ^ b_neg;
        end else if (step_i) begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
        end
    end

    // Stable once stepping ends because acc/neg only move on load or step.
    assign bus.oResult = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 sequential multiplier: IDLE/RUN/DONE control with fixed WIDTH+1
// latency; arithmetic lives in seq_mult_dp.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF  // even, 4..32
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [WIDTH-1:0]   iA,
    input  logic [WIDTH-1:0]   iB,
    input  logic               iSigned,
    input  logic               iStart,
    output logic               oBusy,
    output logic               oDone,
    output logic [2*WIDTH-1:0] oResult
);

    localparam int            CW   = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    seq_mult_if #(.WIDTH(WIDTH)) bus ();

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load, step;

    assign bus.iA      = iA;
    assign bus.iB      = iB;
    assign bus.iSigned = iSigned;
    assign bus.iStart  = iStart;
    assign bus.oBusy   = (state_q == RUN);
    assign bus.oDone   = (state_q == DONE);

    assign oBusy   = bus.oBusy;
    assign oDone   = bus.oDone;
    assign oResult = bus.oResult;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (iStart) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    seq_mult_dp #(.WIDTH(WIDTH)) u_dp (
        .clk    (Clock),
        .rst_n  (Reset),
        .load_i (load),
        .step_i (step),
        .bus    (bus.slave)
    );

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH 4, 16 and 32 against an
// integer-arithmetic reference product.
module tb_seq_multiplier;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t        q4[$], q16[$], q32[$];
    logic [63:0] hold4 = '0, hold16 = '0, hold32 = '0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    seq_mult_if #(.WIDTH(4))  b4  ();
    seq_mult_if #(.WIDTH(16)) b16 ();
    seq_mult_if #(.WIDTH(32)) b32 ();

    seq_multiplier #(.WIDTH(4)) u4 (
        .Clock(Clock), .Reset(Reset), .iA(b4.iA), .iB(b4.iB), .iSigned(b4.iSigned),
        .iStart(b4.iStart), .oBusy(b4.oBusy), .oDone(b4.oDone), .oResult(b4.oResult));
    seq_multiplier #(.WIDTH(16)) u16 (
        .Clock(Clock), .Reset(Reset), .iA(b16.iA), .iB(b16.iB), .iSigned(b16.iSigned),
        .iStart(b16.iStart), .oBusy(b16.oBusy), .oDone(b16.oDone), .oResult(b16.oResult));
    seq_multiplier #(.WIDTH(32)) u32 (
        .Clock(Clock), .Reset(Reset), .iA(b32.iA), .iB(b32.iB), .iSigned(b32.iSigned),
        .iStart(b32.iStart), .oBusy(b32.oBusy), .oDone(b32.oDone), .oResult(b32.oResult));

    // Reference: plain integer product of the operands as interpreted by mode.
    function automatic logic [63:0] model(int w, logic [63:0] a, logic [63:0] b, bit s);
        logic [63:0] m, am, bm, p;
        longint      sa, sb;
        m  = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        am = a & ((64'd1 << w) - 64'd1);
        bm = b & ((64'd1 << w) - 64'd1);
        if (s) begin
            sa = longint'(am << (64 - w)) >>> (64 - w);
            sb = longint'(bm << (64 - w)) >>> (64 - w);
            p  = 64'(sa * sb);
        end else begin
            p = am * bm;
        end
        return p & m;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(int w);
        case (w)
            4:       return q4.size();
            32:      return q32.size();
            default: return q16.size();
        endcase
    endfunction

    // Call just after a falling edge; the next rising edge is the accepting one.
    task automatic issue(int w, logic [63:0] a, logic [63:0] b, bit s, bit push);
        exp_t e;
        e.res = model(w, a, b, s);
        e.cyc = cyc + 1 + w;
        case (w)
            4: begin
                b4.iA = a[3:0]; b4.iB = b[3:0]; b4.iSigned = s; b4.iStart = 1'b1;
                if (push) q4.push_back(e);
            end
            32: begin
                b32.iA = a[31:0]; b32.iB = b[31:0]; b32.iSigned = s; b32.iStart = 1'b1;
                if (push) q32.push_back(e);
            end
            default: begin
                b16.iA = a[15:0]; b16.iB = b[15:0]; b16.iSigned = s; b16.iStart = 1'b1;
                if (push) q16.push_back(e);
            end
        endcase
        @(negedge Clock);
        b4.iStart = 1'b0; b16.iStart = 1'b0; b32.iStart = 1'b0;
    endtask

    task automatic wait_drain(int w);
        int n = 0;
        while (qsize(w) != 0 && n < 4 * w + 20) begin
            @(negedge Clock);
            n++;
        end
        if (qsize(w) != 0) check("drain timeout", 64'(qsize(w)), 64'd0);
    endtask

    // Monitors: busy window, result/latency on oDone, result held while idle.
    always @(negedge Clock) begin
        automatic exp_t m;
        automatic bit   bz;
        if (!Reset) begin
            q4.delete(); hold4 <= '0;
        end else if (b4.oDone) begin
            if (q4.size() == 0) check("w4 unexpected oDone", 64'(b4.oDone), 64'd0);
            else begin
                m = q4.pop_front();
                check("w4 oResult", 64'(b4.oResult), m.res);
                check("w4 latency", 64'(cyc), 64'(m.cyc));
                hold4 <= m.res;
            end
        end else begin
            bz = q4.size() > 0 && cyc >= q4[0].cyc - 4 && cyc < q4[0].cyc;
            check("w4 oBusy", 64'(b4.oBusy), 64'(bz));
            if (!bz) check("w4 held oResult", 64'(b4.oResult), hold4);
        end
    end

    always @(negedge Clock) begin
        automatic exp_t m;
        automatic bit   bz;
        if (!Reset) begin
            q16.delete(); hold16 <= '0;
        end else if (b16.oDone) begin
            if (q16.size() == 0) check("w16 unexpected oDone", 64'(b16.oDone), 64'd0);
            else begin
                m = q16.pop_front();
                check("w16 oResult", 64'(b16.oResult), m.res);
                check("w16 latency", 64'(cyc), 64'(m.cyc));
                hold16 <= m.res;
            end
        end else begin
            bz = q16.size() > 0 && cyc >= q16[0].cyc - 16 && cyc < q16[0].cyc;
            check("w16 oBusy", 64'(b16.oBusy), 64'(bz));
            if (!bz) check("w16 held oResult", 64'(b16.oResult), hold16);
        end
    end

    always @(negedge Clock) begin
        automatic exp_t m;
        automatic bit   bz;
        if (!Reset) begin
            q32.delete(); hold32 <= '0;
        end else if (b32.oDone) begin
            if (q32.size() == 0) check("w32 unexpected oDone", 64'(b32.oDone), 64'd0);
            else begin
                m = q32.pop_front();
                check("w32 oResult", 64'(b32.oResult), m.res);
                check("w32 latency", 64'(cyc), 64'(m.cyc));
                hold32 <= m.res;
            end
        end else begin
            bz = q32.size() > 0 && cyc >= q32[0].cyc - 32 && cyc < q32[0].cyc;
            check("w32 oBusy", 64'(b32.oBusy), 64'(bz));
            if (!bz) check("w32 held oResult", 64'(b32.oResult), hold32);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        exp_t        eb;
        int          e1;
        logic [63:0] a, b, ones, mn;
        bit          s;
        int          ws[3] = '{4, 32, 16};

        b4.iA = '0;  b4.iB = '0;  b4.iSigned = 1'b0;  b4.iStart = 1'b0;
        b16.iA = '0; b16.iB = '0; b16.iSigned = 1'b0; b16.iStart = 1'b0;
        b32.iA = '0; b32.iB = '0; b32.iSigned = 1'b0; b32.iStart = 1'b0;

        #1;
        check("reset w4 oBusy",    64'(b4.oBusy),    64'd0);
        check("reset w4 oDone",    64'(b4.oDone),    64'd0);
        check("reset w4 oResult",  64'(b4.oResult),  64'd0);
        check("reset w16 oBusy",   64'(b16.oBusy),   64'd0);
        check("reset w16 oDone",   64'(b16.oDone),   64'd0);
        check("reset w16 oResult", 64'(b16.oResult), 64'd0);
        check("reset w32 oBusy",   64'(b32.oBusy),   64'd0);
        check("reset w32 oDone",   64'(b32.oDone),   64'd0);
        check("reset w32 oResult", 64'(b32.oResult), 64'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;

        // Directed WIDTH=16 cases
        @(negedge Clock); issue(16, 64'd5, 64'd5, 1'b0, 1'b1);              wait_drain(16);
        @(negedge Clock); issue(16, 64'h8000, 64'h8000, 1'b1, 1'b1);        wait_drain(16);
        @(negedge Clock); issue(16, 64'hFFFF, 64'h0003, 1'b1, 1'b1);        wait_drain(16);
        @(negedge Clock); issue(16, 64'hFFFF, 64'h0003, 1'b0, 1'b1);        wait_drain(16);

        // iStart while busy must be ignored
        @(negedge Clock); issue(16, 64'h1234, 64'h0010, 1'b0, 1'b1);
        repeat (4) @(negedge Clock);
        issue(16, 64'd1, 64'd1, 1'b0, 1'b0);
        wait_drain(16);
        repeat (3) @(negedge Clock);

        // Back-to-back with iStart held high
        @(negedge Clock);
        b16.iA = 16'd7; b16.iB = 16'd9; b16.iSigned = 1'b0; b16.iStart = 1'b1;
        e1 = cyc + 1;
        eb.res = model(16, 64'd7, 64'd9, 1'b0);  eb.cyc = e1 + 16;      q16.push_back(eb);
        @(negedge Clock);
        b16.iA = 16'hFFFF; b16.iB = 16'hFFFF;
        eb.res = model(16, 64'hFFFF, 64'hFFFF, 1'b0); eb.cyc = e1 + 17 + 16; q16.push_back(eb);
        repeat (17) @(negedge Clock);
        b16.iStart = 1'b0;
        wait_drain(16);

        // Reset in RUN cycle 8: aborts, outputs clear at once, restart on release edge
        @(negedge Clock); issue(16, 64'hABCD, 64'h1234, 1'b0, 1'b1);
        repeat (7) @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("midreset oBusy",   64'(b16.oBusy),   64'd0);
        check("midreset oDone",   64'(b16.oDone),   64'd0);
        check("midreset oResult", 64'(b16.oResult), 64'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        issue(16, 64'd2, 64'd3, 1'b0, 1'b1);
        wait_drain(16);

        // Randomized sweep, extremes first, mixed idle gaps and back-to-back
        for (int k = 0; k < 3; k++) begin
            ones = (64'd1 << ws[k]) - 64'd1;
            mn   = 64'd1 << (ws[k] - 1);
            for (int i = 0; i < 40; i++) begin
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                s = 1'($urandom_range(0, 1));
                case (i)
                    0: begin a = mn;    b = mn;    s = 1'b1; end
                    1: begin a = ones;  b = ones;  s = 1'b0; end
                    2: begin a = mn;    b = ones;  s = 1'b1; end
                    3: begin a = 64'd0;            s = 1'b1; end
                    4: begin a = ones;  b = ones;  s = 1'b1; end
                    default: ;
                endcase
                @(negedge Clock);
                issue(ws[k], a, b, s, 1'b1);
                repeat (ws[k] - 1 + $urandom_range(0, 2)) @(negedge Clock);
            end
            wait_drain(ws[k]);
        end

        repeat (3) @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are even and 4..32.
REQ-002 SHALL have port Clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset; 0 resets immediately, independent of Clock.
REQ-004 SHALL have port iA  input  WIDTH  multiplicand.
REQ-005 SHALL have port iB  input  WIDTH  multiplier.
REQ-006 SHALL have port iSigned  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port iStart  input  1  request to begin a multiply.
REQ-008 SHALL have port oBusy  output  1  high while a multiply is in progress.
REQ-009 SHALL have port oDone  output  1  one-cycle pulse when oResult becomes valid.
REQ-010 SHALL have port oResult  output  2*WIDTH  product.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 SHALL accept iStart only in IDLE or DONE; on the accepting edge it SHALL capture iA, iB, iSigned and enter RUN.
REQ-013 SHALL ignore iStart while in RUN; captured operands SHALL not change during RUN.
REQ-014 SHALL perform radix-2 shift-add on operand magnitudes, one multiplier bit per cycle, LSB first, for exactly WIDTH cycles in RUN.
REQ-015 SHALL, in signed mode, take magnitudes of negative operands at capture and negate the 2*WIDTH product at completion when exactly one operand was negative.
REQ-016 SHALL treat the most negative operand (-2^(WIDTH-1)) correctly; its magnitude fits WIDTH unsigned bits.
REQ-017 SHALL enter DONE after the WIDTH-th RUN cycle; oDone SHALL be 1 only during the single DONE cycle.
REQ-018 SHALL have fixed latency: oDone high in the (WIDTH+1)-th cycle after the accepting edge.
REQ-019 SHALL present a correct oResult from the DONE cycle onward and hold it stable until the next accepting edge.
REQ-020 SHALL transition DONE -> IDLE when iStart=0, and DONE -> RUN (back-to-back) when iStart=1.
REQ-021 SHALL drive oBusy = 1 exactly in RUN.
REQ-022 SHALL produce the exact product; the 2*WIDTH result never overflows in either mode.
REQ-023 SHALL leave oResult unspecified during RUN; it is not a valid-qualified output there.

Reset
REQ-024 SHALL, on Reset=0, asynchronously force state IDLE, oBusy=0, oDone=0, oResult=0, and clear all internal registers.
REQ-025 SHALL abort an in-progress multiply when Reset asserts mid-RUN and SHALL not emit oDone for it.
REQ-026 SHALL leave reset on the first rising Clock edge with Reset=1 and accept iStart on that edge.

Structure
REQ-027 SHALL place the state encoding (IDLE, RUN, DONE) and the default WIDTH constant in shared package seq_mult_pkg.
REQ-028 SHALL keep the FSM in seq_multiplier and SHALL place the accumulator/shift datapath in one sub-module, seq_mult_dp.
REQ-029 SHALL size the bit-cycle counter as clog2(WIDTH)+1 bits, derived from WIDTH.

Verification
REQ-030 SHALL check unsigned basic operation: WIDTH=16, iA=5, iB=5, iSigned=0, one-cycle iStart -> oDone in 17th cycle, oResult=0x00000019.
REQ-031 SHALL check signed extremes: iA=0x8000, iB=0x8000, iSigned=1 -> oResult=0x40000000; iA=0xFFFF, iB=0x0003, iSigned=1 -> 0xFFFFFFFD; same operands with iSigned=0 -> 0x0002FFFD.
REQ-032 SHALL check that iStart is ignored while busy: start 0x1234*0x0010, pulse iStart with 0x0001*0x0001 mid-RUN -> single oDone, oResult=0x00012340.
REQ-033 SHALL check back-to-back operation: iStart held high -> oDone every 17 cycles, results 7*9=63 then 0xFFFF*0xFFFF=0xFFFE0001 (unsigned).
REQ-034 SHALL check reset mid-RUN: assert Reset=0 at cycle 8 of RUN -> outputs 0 immediately, no oDone, next start 2*3 -> oResult=6.
REQ-035 SHALL check a parameter sweep: WIDTH=4 and WIDTH=32, randomized operands in both modes compared against a reference model; latency equals WIDTH+1.
